dds_sweep_ctrl: RTL

Frequency-sweep scheduler for the DDS phase accumulator. It steps the 32-bit frequency tuning word that feeds the accumulator's FWORD input. The word starts at a programmed value, changes by a signed step after each dwell interval, and stops once the next step would pass a programmed end value. Software or a host FSM configures it through a small register write port and controls it with start/stop pulses.

---
 rtl/dds_sweep_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// Purpose: frequency-sweep scheduler stepping the DDS tuning word from F_START towards F_STOP.
// Latency: first word one cycle after start; each word is then held DWELL_eff cycles.
// Backpressure: none; config writes while busy are dropped and flagged on cfg_err.
// Optional build macro DDS_SWEEP_LOOP_EN: continuous mode, reload F_START at the end of each pass.
module dds_sweep_ctrl #(
    parameter int FW = 32,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [FW-1:0] cfg_wdata,
    output logic          cfg_err,
    input  logic          start,
    input  logic          stop,
    output logic [FW-1:0] fword_out,
    output logic          fword_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [FW-1:0] r_fstart;
    logic [FW-1:0] r_fstep;
    logic [FW-1:0] r_fstop;
    logic [DW-1:0] r_dwell;

    logic [FW-1:0] r_fword;
    logic [FW-1:0] w_fword_nxt;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] w_cnt_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_busy;
    logic          r_cfg_err;

    logic [DW-1:0] w_dwell_m1;
    logic [FW:0]   w_next;
    logic          w_step_zero;
    logic          w_step_neg;
    logic          w_oor;

    // A programmed dwell of zero behaves like a dwell of one.
    assign w_dwell_m1 = (r_dwell == '0) ? '0 : (r_dwell - DW'(1));

    // Unsigned word plus sign-extended step in FW+1 bits. For either step sign the
    // true result lies in a window where bit FW set means it left [0, 2^FW-1].
    assign w_next      = {1'b0, r_fword} + {r_fstep[FW-1], r_fstep};
    assign w_step_zero = (r_fstep == '0);
    assign w_step_neg  = r_fstep[FW-1];
    assign w_oor       = w_next[FW]
                       | w_step_zero
                       | (!w_step_neg && (w_next[FW-1:0] > r_fstop))
                       | ( w_step_neg && (w_next[FW-1:0] < r_fstop));

    // Next-state and next-output decode; stop has priority over a same-cycle step.
    always_comb begin
        w_state_nxt = r_state;
        w_fword_nxt = r_fword;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_fword_nxt = r_fstart;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = w_dwell_m1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - DW'(1);
                end else if (!w_oor) begin
                    w_fword_nxt = w_next[FW-1:0];
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = w_dwell_m1;
                end else begin
`ifdef DDS_SWEEP_LOOP_EN
                    w_fword_nxt = r_fstart;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = w_dwell_m1;
                    w_done_nxt  = 1'b1;
`else
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered datapath and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fword <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_fword <= w_fword_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Config registers accept writes only in IDLE; a write in any other state is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fstart  <= '0;
            r_fstep   <= '0;
            r_fstop   <= '0;
            r_dwell   <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && (r_state != S_IDLE);
            if (cfg_we && (r_state == S_IDLE)) begin
                case (cfg_addr)
                    2'd0:    r_fstart <= cfg_wdata;
                    2'd1:    r_fstep  <= cfg_wdata;
                    2'd2:    r_fstop  <= cfg_wdata;
                    default: r_dwell  <= cfg_wdata[DW-1:0];
                endcase
            end
        end
    end

    assign fword_out   = r_fword;
    assign fword_valid = r_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cfg_err     = r_cfg_err;

endmodule
